// File: rtl/demux_1x2_buf.sv
// ---------------------------------------------------------------------------
// demux_1x2_buf
//
// Buffered 1-to-2 demultiplexer. Each incoming word goes to one of two output
// channels, chosen by sel when the word is accepted. Each channel has its own
// first-word-fall-through FIFO with a valid/ready handshake, so the two
// consumers can stall independently of each other.
//
// Ports
//   clk, rst_n        single rising-edge clock, asynchronous active-low reset
//   in_data/in_valid  producer word and its qualifier
//   sel               destination channel (0 or 1), only meaningful with in_valid
//   in_ready          the channel named by sel has room (forced 0 in reset)
//   Out_x/valid_x     head word of channel x FIFO (0 when empty) / non-empty
//   ready_x           consumer x takes Out_x at the next rising edge
//   count_x           words accepted into channel x since reset (wraps)
// ---------------------------------------------------------------------------
module demux_1x2_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,   // power of two, >= 2
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             sel,
  output logic             in_ready,
  output logic [WIDTH-1:0] Out_0,
  output logic             valid_0,
  input  logic             ready_0,
  output logic [WIDTH-1:0] Out_1,
  output logic             valid_1,
  input  logic             ready_1,
  output logic [CNT_W-1:0] count_0,
  output logic [CNT_W-1:0] count_1
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]             full;
  logic [1:0]             empty;
  logic [1:0]             push;
  logic [1:0]             pop;
  logic [1:0]             ready_v;
  logic [1:0][WIDTH-1:0]  head;
  logic [1:0][CNT_W-1:0]  count_v;

  assign ready_v = {ready_1, ready_0};

  // Only the selected channel's fullness matters; a full idle channel never
  // blocks traffic headed for the other one. A full FIFO refuses input even
  // if it is being popped in the same cycle (no pass-through on full).
  assign in_ready = rst_n & ~full[sel];

  for (genvar c = 0; c < 2; c++) begin : g_ch
    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the index bits coincide.
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic [WIDTH-1:0]  mem [DEPTH];

    assign empty[c] = (wr_ptr == rd_ptr);
    assign full[c]  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push[c]  = in_valid & in_ready & (sel == 1'(c));
    // ready_x with nothing buffered is ignored, so the FIFO cannot underflow.
    assign pop[c]   = ~empty[c] & ready_v[c];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (push[c]) begin
          wr_ptr  <= wr_ptr + (AW+1)'(1);
          count_q <= count_q + CNT_W'(1);
        end
        if (pop[c]) begin
          rd_ptr <= rd_ptr + (AW+1)'(1);
        end
      end
    end

    // NOTE: the storage array has no reset; emptiness is tracked purely by the
    // pointers, and the output mux hides stale contents while empty.
    always_ff @(posedge clk) begin
      if (push[c]) begin
        mem[wr_ptr[AW-1:0]] <= in_data;
      end
    end

    assign head[c]    = empty[c] ? '0 : mem[rd_ptr[AW-1:0]];
    assign count_v[c] = count_q;
  end

  assign Out_0   = head[0];
  assign Out_1   = head[1];
  assign valid_0 = ~empty[0];
  assign valid_1 = ~empty[1];
  assign count_0 = count_v[0];
  assign count_1 = count_v[1];

endmodule

// File: tb/tb_demux_1x2_buf.sv
// ---------------------------------------------------------------------------
// tb_demux_1x2_buf
//
// Self-checking bench for demux_1x2_buf. A negedge monitor keeps one expected
// queue per channel: words are pushed when the model decides a word is
// accepted, and popped/compared when a consumer takes the head. Table-driven
// vectors carry per-cycle stimulus plus the expected in_ready; hand-written
// sequences cover pointer wrap and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_demux_1x2_buf;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             sel;
  logic             in_ready;
  logic [WIDTH-1:0] Out_0;
  logic             valid_0;
  logic             ready_0;
  logic [WIDTH-1:0] Out_1;
  logic             valid_1;
  logic             ready_1;
  logic [CNT_W-1:0] count_0;
  logic [CNT_W-1:0] count_1;

  demux_1x2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .sel      (sel),
    .in_ready (in_ready),
    .Out_0    (Out_0),
    .valid_0  (valid_0),
    .ready_0  (ready_0),
    .Out_1    (Out_1),
    .valid_1  (valid_1),
    .ready_1  (ready_1),
    .count_0  (count_0),
    .count_1  (count_1)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic [CNT_W-1:0] m_cnt0 = '0;
  logic [CNT_W-1:0] m_cnt1 = '0;
  int               rx0 = 0;
  int               rx1 = 0;

  always @(negedge clk) begin
    logic exp_ready;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      m_cnt0 = '0;
      m_cnt1 = '0;
    end
    exp_ready = rst_n && ((sel ? q1.size() : q0.size()) < DEPTH);
    check("mon_in_ready", in_ready, exp_ready);
    check("mon_valid_0", valid_0, q0.size() != 0);
    check("mon_valid_1", valid_1, q1.size() != 0);
    check("mon_count_0", count_0, m_cnt0);
    check("mon_count_1", count_1, m_cnt1);

    if (q0.size() == 0) check("mon_out_0_empty", Out_0, '0);
    else begin
      check("mon_out_0_head", Out_0, q0[0]);
      if (ready_0) begin
        void'(q0.pop_front());
        rx0++;
      end
    end
    if (q1.size() == 0) check("mon_out_1_empty", Out_1, '0);
    else begin
      check("mon_out_1_head", Out_1, q1[0]);
      if (ready_1) begin
        void'(q1.pop_front());
        rx1++;
      end
    end

    if (rst_n && in_valid && exp_ready) begin
      if (sel) begin
        q1.push_back(in_data);
        m_cnt1 = m_cnt1 + 1'b1;
      end else begin
        q0.push_back(in_data);
        m_cnt0 = m_cnt0 + 1'b1;
      end
    end
  end

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic             v;
    logic             s;
    logic [WIDTH-1:0] d;
    logic             r0;
    logic             r1;
    logic             exp_rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs are applied just after a rising edge; in_ready is checked before
  // the next edge.
  task automatic apply(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      in_valid = vecs[i].v;
      sel      = vecs[i].s;
      in_data  = vecs[i].d;
      ready_0  = vecs[i].r0;
      ready_1  = vecs[i].r1;
      #1;
      check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].exp_rdy);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int i;
    int cyc;
    int rx0_start;
    logic acc;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    sel      = 1'b0;
    in_data  = '0;
    ready_0  = 1'b1;
    ready_1  = 1'b1;

    // Route alternating (0..4)
    vecs.push_back('{1'b1, 1'b0, 32'hA0, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 32'hB1, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'hA2, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1});
    // Full / backpressure (5..11)
    vecs.push_back('{1'b1, 1'b0, 32'h10, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'h11, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'h12, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'h12, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1});
    // Full with pop: refused while full, accepted the following cycle (12..17)
    vecs.push_back('{1'b1, 1'b0, 32'h20, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'h21, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'h22, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h22, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1});

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_valid_0", valid_0, 1'b0);
    check("rst_valid_1", valid_1, 1'b0);
    check("rst_out_0", Out_0, '0);
    check("rst_out_1", Out_1, '0);
    check("rst_count_0", count_0, '0);
    check("rst_count_1", count_1, '0);
    check("rst_in_ready", in_ready, 1'b1);
    tick();

    apply(0, 4);
    check("alt_count_0", count_0, 2);
    check("alt_count_1", count_1, 1);
    check("alt_rx0", rx0, 2);
    check("alt_rx1", rx1, 1);

    apply(5, 11);
    check("bp_count_0", count_0, 4);
    check("bp_count_1", count_1, 2);
    check("bp_drained_0", valid_0, 1'b0);

    apply(12, 17);
    check("fullpop_count_0", count_0, 7);
    check("fullpop_rx0", rx0, 7);

    // Pointer wrap: 10 words through channel 0, ready_0 toggling each cycle
    do_reset();
    tick();
    rx0_start = rx0;
    i   = 0;
    cyc = 0;
    in_valid = 1'b1;
    sel      = 1'b0;
    while (i < 10 && cyc < 200) begin
      in_data = 32'h100 + i;
      ready_0 = cyc[0];
      #1;
      acc = in_ready;
      tick();
      if (acc) i++;
      cyc++;
    end
    in_valid = 1'b0;
    ready_0  = 1'b1;
    check("wrap_accepted", i, 10);
    repeat (DEPTH + 2) tick();
    check("wrap_count_0", count_0, 10);
    check("wrap_rx0", rx0 - rx0_start, 10);
    check("wrap_empty", valid_0, 1'b0);

    // Async reset mid-stream: two words parked in channel 1
    ready_1  = 1'b0;
    in_valid = 1'b1;
    sel      = 1'b1;
    in_data  = 32'h30;
    tick();
    in_data  = 32'h31;
    tick();
    in_valid = 1'b0;
    check("ar_valid_1_before", valid_1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid_1_drop", valid_1, 1'b0);
    check("ar_out_1_zero", Out_1, '0);
    check("ar_in_ready_low", in_ready, 1'b0);
    check("ar_count_1_zero", count_1, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    ready_1 = 1'b1;
    repeat (3) tick();
    check("ar_no_stale", valid_1, 1'b0);

    // A fresh push after reset
    in_valid = 1'b1;
    sel      = 1'b1;
    in_data  = 32'h40;
    ready_1  = 1'b0;
    tick();
    in_valid = 1'b0;
    check("ar_new_valid", valid_1, 1'b1);
    check("ar_new_data", Out_1, 32'h40);
    check("ar_new_count", count_1, 1);
    ready_1 = 1'b1;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
